// File: rtl/dff_chain.sv
// Parameterised register chain: serial shift, parallel load and rotate in either
// direction, with a saturating fill counter.
module dff_chain #(
    parameter int unsigned            WIDTH     = 1,
    parameter int unsigned            DEPTH     = 4,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       En,
    input  logic [1:0]                 Mode,
    input  logic                       Dir,
    input  logic [WIDTH-1:0]           D,
    input  logic [DEPTH*WIDTH-1:0]     ParD,
    output logic [WIDTH-1:0]           Q,
    output logic [DEPTH*WIDTH-1:0]     ParQ,
    output logic [$clog2(DEPTH+1)-1:0] FillCount,
    output logic                       Full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHIFT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_ROT   = 2'b11
    } mode_e;

    mode_e            op;
    logic [WIDTH-1:0] stage [DEPTH];
    logic [CW-1:0]    fill;

    always_comb op = mode_e'(Mode);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            fill <= '0;
        end else if (En) begin
            case (op)
                MODE_SHIFT, MODE_ROT: begin
                    if (!Dir) begin
                        // Vacated end takes D on shift, the outgoing stage on rotate.
                        stage[0] <= (op == MODE_SHIFT) ? D : stage[DEPTH-1];
                        for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                    end else begin
                        stage[DEPTH-1] <= (op == MODE_SHIFT) ? D : stage[0];
                        for (int unsigned i = 0; i < DEPTH - 1; i++) stage[i] <= stage[i+1];
                    end
                    if (op == MODE_SHIFT && fill != CW'(DEPTH)) fill <= fill + 1'b1;
                end
                MODE_LOAD: begin
                    for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= ParD[i*WIDTH +: WIDTH];
                    fill <= CW'(DEPTH);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ParQ = '0;
        for (int unsigned i = 0; i < DEPTH; i++) ParQ[i*WIDTH +: WIDTH] = stage[i];
    end

    assign Q         = Dir ? stage[0] : stage[DEPTH-1];
    assign FillCount = fill;
    assign Full      = (fill == CW'(DEPTH));

endmodule

// File: doc/dff_chain.md
DFF_CHAIN -- requirements
Module: dff_chain

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, meaning bits per stage (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning number of register stages (>=2).
REQ-003 The module SHALL have parameter RESET_VAL, default 0, meaning the WIDTH-bit value loaded into every stage on reset.
REQ-004 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 En  input  1  SHALL be the clock enable; when low, all state holds.
REQ-007 Mode  input  2  SHALL select the operation: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-008 Dir  input  1  SHALL select the direction: 0 = stage k to k+1 (in at stage 0); 1 = stage k+1 to k (in at stage DEPTH-1).
REQ-009 D  input  WIDTH  SHALL be the serial data input.
REQ-010 ParD  input  DEPTH*WIDTH  SHALL be the parallel load data; stage k = ParD[k*WIDTH +: WIDTH].
REQ-011 Q  output  WIDTH  SHALL be the serial output: stage DEPTH-1 when Dir=0, stage 0 when Dir=1.
REQ-012 ParQ  output  DEPTH*WIDTH  SHALL present all stages, with the same packing as ParD.
REQ-013 FillCount  output  $clog2(DEPTH+1)  SHALL give the number of valid entries shifted or loaded since reset.
REQ-014 Full  output  1  SHALL be high iff FillCount == DEPTH.

Function
REQ-015 All outputs SHALL be driven directly from registers or from a combinational decode of registers and Dir; there is no extra output register stage.
REQ-016 Hold (Mode=00), or En=0 with any Mode, SHALL leave stages and FillCount unchanged.
REQ-017 Shift, Dir=0: stage 0 <= D; stage k <= stage k-1 for k=1..DEPTH-1.
REQ-018 Shift, Dir=1: stage DEPTH-1 <= D; stage k <= stage k+1 for k=0..DEPTH-2.
REQ-019 Shift SHALL increment FillCount by 1, saturating at DEPTH; no wrap to 0.
REQ-020 Parallel load SHALL write every stage from ParD in one cycle and set FillCount = DEPTH.
REQ-021 Rotate SHALL move data as for shift, but feed the vacated end from the outgoing end stage instead of D; D is ignored.
REQ-022 Rotate SHALL leave FillCount unchanged.
REQ-023 Latency: with Mode=01 held at a fixed Dir, D sampled at edge n SHALL appear on Q after edge n+DEPTH-1.
REQ-024 Dir changes SHALL take effect at the next edge for data movement; Q selection SHALL follow Dir combinationally.
REQ-025 Illegal or unknown Mode is not possible (all 4 codes defined); X on Mode is a bench error, not a design case.
REQ-026 The design SHALL be fully synthesizable, with no latches and no asynchronous logic.

Reset
REQ-027 When Reset=1 at a rising Clk edge, every stage <= RESET_VAL and FillCount <= 0, regardless of En, Mode or Dir.
REQ-028 Reset SHALL take priority over all operations, including mid-shift and mid-load.
REQ-029 After reset, Q = RESET_VAL, ParQ = DEPTH copies of RESET_VAL, and Full = 0.
REQ-030 The first non-reset edge SHALL operate normally; no dead cycle.

Verification (WIDTH=4, DEPTH=4, RESET_VAL=0)
REQ-031 Reset then shift Dir=0 with D=1,2,3,4 on 4 edges -> ParQ stages [0..3] = 4,3,2,1; Q=1; FillCount=4; Full=1.
REQ-032 Continue shift with D=5 -> ParQ = 5,4,3,2; FillCount stays 4 (saturates); Q=2.
REQ-033 Load ParD stages = A,B,C,D, then rotate Dir=1 for one edge -> stages = B,C,D,A; Q=B; FillCount=4.
REQ-034 Load, hold D=F with En=0 and Mode=01 for 3 edges -> ParQ unchanged; FillCount unchanged.
REQ-035 Shift 2 values, then Reset=1 together with Mode=10 -> all stages 0; FillCount=0; Full=0; next shift of D=7 -> stage 0 = 7, FillCount=1.
REQ-036 Shift Dir=1 with D=9 then D=6 -> stage 3 = 6, stage 2 = 9; Q (stage 0) = 0; FillCount=2.
